// File: rtl/mux_nch_stream_pkg.sv
// Shared constants, output-stage state type and one-hot helper for mux_nch_stream.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
    localparam int   MUX_MAX_CH = 16;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } out_state_t;

    // OR-ing the indices of set bits gives the exact index for a one-hot input.
    function automatic int onehot_to_idx(input logic [MUX_MAX_CH-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MUX_MAX_CH; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux_nch_stream_rr_arbiter.sv
// Combinational rotate-priority encoder: the first request after ptr wins.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic                grant_vld,
    output logic [SEL_W-1:0]    grant_idx
);

    logic [CHANNELS-1:0]   grant_oh;
    logic [MUX_MAX_CH-1:0] oh_pad;

    always_comb begin
        grant_oh  = '0;
        grant_vld = 1'b0;
        for (int i = 1; i <= CHANNELS; i++) begin
            if (!grant_vld && req[(int'(ptr) + i) % CHANNELS]) begin
                grant_oh[(int'(ptr) + i) % CHANNELS] = 1'b1;
                grant_vld = 1'b1;
            end
        end
        oh_pad                 = '0;
        oh_pad[CHANNELS-1:0]   = grant_oh;
        grant_idx              = SEL_W'(onehot_to_idx(oh_pad));
    end

endmodule

// File: rtl/mux_nch_stream.sv
// N-channel stream mux with fixed-select or round-robin grant and a one-deep output register.
// Define MUX_NCH_PARITY_EN to add the registered y_parity_out port.
module mux_nch_stream
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      mode_in,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [CHANNELS-1:0]       valid_in,
    output logic [CHANNELS-1:0]       ready_out,
    output logic [WIDTH-1:0]          y_out,
    output logic                      y_valid_out,
    output logic [SEL_W-1:0]          y_ch_out,
`ifdef MUX_NCH_PARITY_EN
    output logic                      y_parity_out,
`endif
    input  logic                      y_ready_in
);

    out_state_t       state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             rr_vld;
    logic [SEL_W-1:0] rr_idx;
    logic             fix_vld;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] word;

    rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
        .req       (valid_in),
        .ptr       (rr_ptr_q),
        .grant_vld (rr_vld),
        .grant_idx (rr_idx)
    );

    always_comb begin
        // Compare against each legal index so an out-of-range sel_in never indexes valid_in.
        fix_vld = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (sel_in == SEL_W'(c) && valid_in[c]) fix_vld = 1'b1;
        end
        grant_vld = (mode_in == MODE_RR) ? rr_vld : fix_vld;
        grant_idx = (mode_in == MODE_RR) ? rr_idx : sel_in;
        load_en   = (state_q == ST_EMPTY) || y_ready_in;
        xfer      = load_en && grant_vld && !rst_in;

        ready_out = '0;
        word      = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (grant_idx == SEL_W'(c)) begin
                word         = data_in[c*WIDTH +: WIDTH];
                ready_out[c] = xfer;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        ch_d     = ch_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_EMPTY: if (xfer) state_d = ST_FULL;
            ST_FULL:  if (y_ready_in && !xfer) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
        if (xfer) begin
            y_d  = word;
            ch_d = grant_idx;
            if (mode_in == MODE_RR) rr_ptr_d = grant_idx;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= ST_EMPTY;
            y_q      <= '0;
            ch_q     <= '0;
            rr_ptr_q <= SEL_W'(CHANNELS - 1);
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            ch_q     <= ch_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign y_out       = y_q;
    assign y_ch_out    = ch_q;
    assign y_valid_out = (state_q == ST_FULL);

`ifdef MUX_NCH_PARITY_EN
    logic par_q, par_d;

    always_comb begin
        par_d = xfer ? ^word : par_q;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) par_q <= 1'b0;
        else        par_q <= par_d;
    end

    assign y_parity_out = par_q;
`endif

endmodule

// File: tb/tb_mux_nch_stream.sv
// Directed bench for mux_nch_stream: a 4-channel instance plus a 3-channel instance for out-of-range select.
module tb_mux_nch_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [3:0]  valid;
    logic [3:0]  ready;
    logic [7:0]  y;
    logic        yv;
    logic [1:0]  ych;
    logic        yr;

    logic        mode3;
    logic [1:0]  sel3;
    logic [23:0] data3;
    logic [2:0]  valid3;
    logic [2:0]  ready3;
    logic [7:0]  y3;
    logic        yv3;
    logic [1:0]  ych3;
    logic        yr3;
`ifdef MUX_NCH_PARITY_EN
    logic        par, par3;
`endif

    int n_tot  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mux_nch_stream #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk_in      (clk),
        .rst_in      (rst),
        .mode_in     (mode),
        .sel_in      (sel),
        .data_in     (data),
        .valid_in    (valid),
        .ready_out   (ready),
        .y_out       (y),
        .y_valid_out (yv),
        .y_ch_out    (ych),
`ifdef MUX_NCH_PARITY_EN
        .y_parity_out(par),
`endif
        .y_ready_in  (yr)
    );

    mux_nch_stream #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk_in      (clk),
        .rst_in      (rst),
        .mode_in     (mode3),
        .sel_in      (sel3),
        .data_in     (data3),
        .valid_in    (valid3),
        .ready_out   (ready3),
        .y_out       (y3),
        .y_valid_out (yv3),
        .y_ch_out    (ych3),
`ifdef MUX_NCH_PARITY_EN
        .y_parity_out(par3),
`endif
        .y_ready_in  (yr3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        logic [1:0] rr_ch[6];
        logic [7:0] rr_y[6];
        logic [3:0] alt_rdy[4];
        logic [1:0] alt_ch[4];
        rr_ch   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rr_y    = '{8'h11, 8'h22, 8'hA5, 8'h3C, 8'h11, 8'h22};
        alt_rdy = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
        alt_ch  = '{2'd3, 2'd1, 2'd3, 2'd1};

        rst = 1'b1; mode = 1'b0; sel = 2'd0; valid = 4'hF; yr = 1'b1;
        data = {8'h3C, 8'hA5, 8'h22, 8'h11};
        mode3 = 1'b0; sel3 = 2'd3; valid3 = 3'b111; yr3 = 1'b1;
        data3 = {8'h09, 8'h08, 8'h07};
        #2;
        chk("rst_valid", yv, 0);
        chk("rst_y", y, 0);
        chk("rst_ch", ych, 0);
        chk("rst_ready", ready, 0);
`ifdef MUX_NCH_PARITY_EN
        chk("rst_parity", par, 0);
`endif
        @(negedge clk); rst = 1'b0;

        // Fixed mode, sel 3
        sel = 2'd3; #1;
        chk("fix_ready", ready, 4'b1000);
        chk("oor_ready", ready3, 0);
        @(posedge clk); #1;
        chk("fix_y", y, 8'h3C);
        chk("fix_ch", ych, 3);
        chk("fix_valid", yv, 1);
        chk("oor_valid", yv3, 0);
        chk("fix_ready_b2b", ready, 4'b1000);
        data[31:24] = 8'h3D;
        @(posedge clk); #1;
        chk("fix_y_next", y, 8'h3D);
        chk("oor_valid2", yv3, 0);
        chk("oor_ready2", ready3, 0);
`ifdef MUX_NCH_PARITY_EN
        chk("par_3d", par, 1);
`endif

        // 3-channel instance with an in-range select
        sel3 = 2'd0; #1;
        chk("c3_ready", ready3, 3'b001);
        @(posedge clk); #1;
        chk("c3_y", y3, 8'h07);
        chk("c3_ch", ych3, 0);
        chk("c3_valid", yv3, 1);
`ifdef MUX_NCH_PARITY_EN
        chk("par_07", par3, 1);
`endif

        // Round-robin, all valid; pointer still at reset value 3
        data[31:24] = 8'h3C;
        mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("rr4_ch", ych, rr_ch[k]);
            chk("rr4_y", y, rr_y[k]);
        end

        // Round-robin on channels 1 and 3 only; pointer is 1
        valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("alt_ready", ready, alt_rdy[k]);
            @(posedge clk); #1;
            chk("alt_ch", ych, alt_ch[k]);
        end

        // Stall with y = 0x22 from ch1 held
        valid = 4'hF; yr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_ready", ready, 0);
            @(posedge clk); #1;
            chk("stall_y", y, 8'h22);
            chk("stall_ch", ych, 1);
            chk("stall_valid", yv, 1);
        end
`ifdef MUX_NCH_PARITY_EN
        chk("par_22", par, 0);
`endif
        yr = 1'b1; #1;
        chk("release_ready", ready, 4'b0100);
        @(posedge clk); #1;
        chk("release_ch", ych, 2);
        chk("release_y", y, 8'hA5);
        chk("release_valid", yv, 1);

        // Drain: no requests, output empties and holds data
        valid = 4'h0; #1;
        chk("drain_ready", ready, 0);
        @(posedge clk); #1;
        chk("drain_valid", yv, 0);
        chk("drain_y", y, 8'hA5);
        chk("drain_ch", ych, 2);

        // Fixed mode on a channel that is not valid
        mode = 1'b0; sel = 2'd1; valid = 4'b0100; #1;
        chk("nogrant_ready", ready, 0);

        // Load 0xA5 from ch2, then reset between edges
        sel = 2'd2; #1;
        chk("ch2_ready", ready, 4'b0100);
        @(posedge clk); #1;
        chk("pre_rst_valid", yv, 1);
        chk("pre_rst_y", y, 8'hA5);
        #2; rst = 1'b1; #1;
        chk("midrst_valid", yv, 0);
        chk("midrst_y", y, 0);
        chk("midrst_ch", ych, 0);
        chk("midrst_ready", ready, 0);
        @(negedge clk); rst = 1'b0;
        mode = 1'b1; valid = 4'hF; #1;
        chk("post_rst_ready", ready, 4'b0001);
        @(posedge clk); #1;
        chk("post_rst_ch", ych, 0);
        chk("post_rst_y", y, 8'h11);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/mux_nch_stream.md
Name: mux_nch_stream

Overview:
- Parametrised N-channel, W-bit successor to the 2:1 select mux.
- Adds a registered output stage with valid/ready handshakes on every input and on the output.
- Two selection modes: fixed select (software-steered, as the 2:1 mux) and round-robin arbitration across requesting channels.
- Sits between multiple producer streams and a single consumer; one-deep buffering, no combinational path from y_ready_in to data.

Parameters:
- WIDTH, 8, data bits per channel.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, $clog2(CHANNELS) (localparam, derived), width of select and channel-ID fields.

Ports:
- clk_in  input  1  clock; all state on rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- mode_in  input  1  0 = fixed select, 1 = round-robin.
- sel_in  input  SEL_W  channel selected in fixed mode; ignored in round-robin.
- data_in  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- valid_in  input  CHANNELS  per-channel valid.
- ready_out  output  CHANNELS  per-channel ready; at most one bit set per cycle.
- y_out  output  WIDTH  registered output data.
- y_valid_out  output  1  output holds a valid word.
- y_ch_out  output  SEL_W  source channel of the word in y_out.
- y_ready_in  input  1  consumer accepts y_out this cycle.

Behaviour:
- Reset (asynchronous, any time): y_out=0, y_valid_out=0, y_ch_out=0, ready_out=0, rr_ptr=CHANNELS-1 (channel 0 highest priority first). A word held in the output register is dropped.
- Output stage has two states:
  - EMPTY: y_valid_out=0.
  - FULL: y_valid_out=1.
- load_en = !y_valid_out || y_ready_in (pipeline-ready; full throughput when the consumer is always ready).
- Grant, computed combinationally each cycle:
  - Fixed mode: grant = sel_in when sel_in < CHANNELS and valid_in[sel_in]=1; otherwise no grant.
  - Round-robin mode: grant = the first c with valid_in[c]=1, scanning rr_ptr+1, rr_ptr+2, … modulo CHANNELS. No grant when valid_in=0.
- ready_out[grant] = load_en && grant exists. All other ready_out bits are 0. Ready never asserts for a channel whose valid is low.
- Transfer on an input channel = valid_in[c] && ready_out[c].
- On a transfer: next cycle y_out = data of channel c, y_ch_out = c, y_valid_out = 1.
- In round-robin mode, rr_ptr ← c on a transfer only.
- Output latency: exactly 1 cycle from input transfer to y_valid_out.
- Consumer takes the word (y_ready_in=1) with no new grant → EMPTY next cycle. y_out and y_ch_out hold their last values.
- Consumer stalls (y_valid_out=1, y_ready_in=0) → y_out, y_ch_out and y_valid_out are held stable, and all ready_out bits are 0.
- Simultaneous output accept and new grant → back-to-back transfer; the output stage stays FULL with new data.
- Mode change: takes effect the same cycle (grant logic is combinational). rr_ptr is retained across fixed-mode periods and is not updated in fixed mode.
- sel_in out of range (≥ CHANNELS): no grant; no X propagation.
- Wrap-around: rr_ptr = CHANNELS-1 → scan starts at channel 0.

Optional Feature:
- Macro: MUX_NCH_PARITY_EN.
- Defined: adds output port y_parity_out (1 bit) = even parity (XOR-reduce) of the captured data word. It is registered with y_out, reset to 0 and held on stall.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package mux_pkg:
  - mode constants MODE_FIXED=1'b0, MODE_RR=1'b1.
  - Maximum-channel constant MUX_MAX_CH=16.
  - Function for one-hot-to-index conversion.
- Sub-module rr_arbiter (parameter CHANNELS):
  - inputs: req, ptr.
  - outputs: grant_vld, grant_idx.
  - Purely combinational rotate-priority encoder.
  - mux_nch_stream instantiates it and owns rr_ptr and the output register.

Test Plan:
- Reset mid-stream: load 0xA5 from ch2, assert rst_in asynchronously between edges → y_valid_out=0, y_out=0 immediately, and the first RR grant after reset goes to ch0.
- Fixed mode, sel_in=3, valid_in=4'b1111, y_ready_in=1 → only ready_out[3]=1; y_out=data ch3 one cycle later with y_ch_out=3; one word per cycle.
- Round-robin, all four channels valid continuously, y_ready_in=1 → y_ch_out sequence 0,1,2,3,0,1 on consecutive cycles.
- Round-robin with valid_in=4'b1010 → y_ch_out alternates 1,3,1,3; channels 0 and 2 never get ready.
- Stall: y_ready_in=0 for 5 cycles with y_valid_out=1 → y_out stable, ready_out=0; on release, the next word follows the same cycle (back-to-back).
- Fixed mode with sel_in=3 at CHANNELS=3, valid_in all 1 → ready_out=0 and y_valid_out stays 0. With MUX_NCH_PARITY_EN, a word of 0x07 → y_parity_out=1.
